red_unpack: RTL

RED_UNPACK -- requirements
Module: red_unpack

---
 rtl/red_unpack.sv | 104 ++++++++++
 1 files changed

// File: rtl/red_unpack.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// red_unpack: splits an rs/rt operand pair into four extended bytes, one per
// output handshake, with zero-bubble back-to-back pairs.   Rev 1.0
// =============================================================================
module red_unpack #(
  parameter int MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] rs,
  input  logic [15:0] rt,
  input  logic        sext,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_idx,
  output logic        out_last,
  output logic        busy
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EMIT = 1'b1;
  // Byte slots are numbered a=0, b=1, c=2, d=3; low-byte-first swaps within each register.
  localparam logic [1:0] ORDER_FLIP = (MSB_FIRST != 0) ? 2'b00 : 2'b01;

  logic        state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] rs_q, rs_d;
  logic [15:0] rt_q, rt_d;
  logic        sext_q, sext_d;

  logic        in_hs, out_hs;
  logic [1:0]  byte_sel;
  logic [7:0]  cur_byte;

  always_comb begin
    out_valid = (state_q == ST_EMIT);
    busy      = out_valid;
    out_last  = out_valid && (idx_q == 2'd3);
    in_ready  = (state_q == ST_IDLE) || (out_last && out_ready);
    in_hs     = in_valid && in_ready;
    out_hs    = out_valid && out_ready;
    out_idx   = idx_q;

    byte_sel = idx_q ^ ORDER_FLIP;
    case (byte_sel)
      2'd0:    cur_byte = rs_q[15:8];
      2'd1:    cur_byte = rs_q[7:0];
      2'd2:    cur_byte = rt_q[15:8];
      default: cur_byte = rt_q[7:0];
    endcase

    if (out_valid) begin
      out_data = {(sext_q ? {8{cur_byte[7]}} : 8'h00), cur_byte};
    end else begin
      out_data = 16'h0000;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    sext_d  = sext_q;
    // In EMIT an input handshake can only coincide with the final-byte handshake.
    if (in_hs) begin
      state_d = ST_EMIT;
      idx_d   = 2'd0;
      rs_d    = rs;
      rt_d    = rt;
      sext_d  = sext;
    end else if (out_hs) begin
      if (idx_q == 2'd3) begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      rs_q    <= 16'h0000;
      rt_q    <= 16'h0000;
      sext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      sext_q  <= sext_d;
    end
  end

endmodule
`default_nettype wire
